// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: instruction fields, opcodes, ALU selects,
// controller FSM states and the jump classification produced by the decoder.
package cpu_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned OPR_W   = 4;
    localparam int unsigned INSTR_W = OPC_W + OPR_W;
    localparam int unsigned DATA_W  = 4;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned SEL_W   = 3;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_AND = 4'h4;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h6;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h9;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hA;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    // Select codes understood by the external alu block
    localparam logic [SEL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [SEL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [SEL_W-1:0] ALU_AND = 3'b010;
    localparam logic [SEL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [SEL_W-1:0] ALU_XOR = 3'b100;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        JMP_NONE   = 2'd0,
        JMP_ALWAYS = 2'd1,
        JMP_Z      = 2'd2,
        JMP_C      = 2'd3
    } jump_e;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder for cpu_control. Opcodes 0xB-0xE are flagged
// illegal only when CPU_ILLEGAL_TRAP_EN is defined; otherwise they decode as NOP.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic [SEL_W-1:0] alu_sel_o,
    output logic             acc_we_o,
    output logic             acc_from_alu_o,
    output logic             flag_we_o,
    output jump_e            jump_o,
    output logic             is_out_o,
    output logic             is_halt_o,
    output logic             is_illegal_o
);

`ifdef CPU_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    // Opcode to control-bundle decode
    always_comb begin
        alu_sel_o      = ALU_ADD;
        acc_we_o       = 1'b0;
        acc_from_alu_o = 1'b0;
        flag_we_o      = 1'b0;
        jump_o         = JMP_NONE;
        is_out_o       = 1'b0;
        is_halt_o      = 1'b0;
        is_illegal_o   = 1'b0;
        case (opcode_i)
            OP_NOP: ;
            OP_LDI: acc_we_o = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                acc_we_o       = 1'b1;
                acc_from_alu_o = 1'b1;
                flag_we_o      = 1'b1;
                case (opcode_i)
                    OP_ADD:  alu_sel_o = ALU_ADD;
                    OP_SUB:  alu_sel_o = ALU_SUB;
                    OP_AND:  alu_sel_o = ALU_AND;
                    OP_OR:   alu_sel_o = ALU_OR;
                    OP_XOR:  alu_sel_o = ALU_XOR;
                    default: alu_sel_o = ALU_ADD;
                endcase
            end
            OP_JMP: jump_o    = JMP_ALWAYS;
            OP_JZ:  jump_o    = JMP_Z;
            OP_JC:  jump_o    = JMP_C;
            OP_OUT: is_out_o  = 1'b1;
            OP_HLT: is_halt_o = 1'b1;
            4'hB, 4'hC, 4'hD, 4'hE: is_illegal_o = TRAP_EN;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// Fetch/decode/execute controller for the 4-bit CPU; three cycles per instruction.
// Optional illegal-opcode trap is enabled by defining CPU_ILLEGAL_TRAP_EN.
module cpu_control
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PC_RESET = 4'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SEL_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    output logic [DATA_W-1:0]  acc_out,
    output logic               flag_c,
    output logic               flag_z,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               halted,
    output logic               illegal
);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]    acc_q, acc_d;
    logic                 flag_c_q, flag_c_d;
    logic                 flag_z_q, flag_z_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 halted_q, halted_d;
    logic                 illegal_q, illegal_d;

    logic [SEL_W-1:0]     dec_alu_sel_s;
    logic                 dec_acc_we_s;
    logic                 dec_acc_from_alu_s;
    logic                 dec_flag_we_s;
    jump_e                dec_jump_s;
    logic                 dec_is_out_s;
    logic                 dec_is_halt_s;
    logic                 dec_is_illegal_s;
    logic                 jump_taken_s;
    logic [OPR_W-1:0]     operand_s;

    assign operand_s = ir_q[OPR_W-1:0];

    instr_decoder u_dec (
        .opcode_i       (ir_q[INSTR_W-1:OPR_W]),
        .alu_sel_o      (dec_alu_sel_s),
        .acc_we_o       (dec_acc_we_s),
        .acc_from_alu_o (dec_acc_from_alu_s),
        .flag_we_o      (dec_flag_we_s),
        .jump_o         (dec_jump_s),
        .is_out_o       (dec_is_out_s),
        .is_halt_o      (dec_is_halt_s),
        .is_illegal_o   (dec_is_illegal_s)
    );

    // Conditional jumps test the flags as they stood before this instruction
    always_comb begin
        jump_taken_s = 1'b0;
        case (dec_jump_s)
            JMP_ALWAYS: jump_taken_s = 1'b1;
            JMP_Z:      jump_taken_s = flag_z_q;
            JMP_C:      jump_taken_s = flag_c_q;
            default:    jump_taken_s = 1'b0;
        endcase
    end

    // Next-state and commit logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        halted_d    = halted_q;
        illegal_d   = illegal_q;
        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    ir_d    = instr_data;
                    pc_d    = pc_q + 4'd1;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (dec_acc_we_s) begin
                    if (dec_acc_from_alu_s) begin
                        acc_d = alu_result;
                    end else begin
                        acc_d = operand_s;
                    end
                end else begin
                    acc_d = acc_q;
                end
                if (dec_flag_we_s) begin
                    flag_c_d = alu_carry;
                    flag_z_d = alu_zero;
                end else begin
                    flag_c_d = flag_c_q;
                    flag_z_d = flag_z_q;
                end
                if (jump_taken_s) begin
                    pc_d = operand_s;
                end else begin
                    pc_d = pc_q;
                end
                if (dec_is_out_s) begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                end else begin
                    out_data_d  = out_data_q;
                    out_valid_d = 1'b0;
                end
                if (dec_is_halt_s || dec_is_illegal_s) begin
                    state_d   = ST_HALT;
                    halted_d  = 1'b1;
                    illegal_d = illegal_q | dec_is_illegal_s;
                end else begin
                    state_d   = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= PC_RESET;
            ir_q        <= 8'h00;
            acc_q       <= 4'h0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            out_data_q  <= 4'h0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign instr_addr = pc_q;
    assign alu_a      = acc_q;
    assign alu_b      = operand_s;
    assign alu_sel    = dec_alu_sel_s;
    assign acc_out    = acc_q;
    assign flag_c     = flag_c_q;
    assign flag_z     = flag_z_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_cpu_control.sv
// Scoreboard bench for cpu_control: an instruction-level model predicts OUT values
// and final architectural state for directed and random ROM programs.
module tb_cpu_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [3:0] instr_addr;
    logic [7:0] instr_data;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_sel;
    logic       alu_carry, alu_zero;
    logic [3:0] acc_out, out_data;
    logic       flag_c, flag_z, out_valid, halted, illegal;

    logic [7:0] rom [16];
    logic [3:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cyc0 = 0;
    int first_out_cyc = -1;
    int halt_cyc = 0;
    logic [3:0] m_acc, m_pc;
    logic       m_c, m_z, m_ill;

    cpu_control #(.PC_RESET(4'd0)) dut (
        .clk(clk), .rst(rst), .run(run),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .acc_out(acc_out), .flag_c(flag_c), .flag_z(flag_z),
        .out_data(out_data), .out_valid(out_valid),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign instr_data = rom[instr_addr];

    // Stand-in for the external alu: carry is carry-out on ADD, borrow on SUB
    always_comb begin
        logic [4:0] t;
        t = 5'd0;
        case (alu_sel)
            3'b000:  t = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  t = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  t = {1'b0, alu_a & alu_b};
            3'b011:  t = {1'b0, alu_a | alu_b};
            3'b100:  t = {1'b0, alu_a ^ alu_b};
            default: t = 5'd0;
        endcase
        alu_result = t[3:0];
        alu_carry  = t[4];
        alu_zero   = (t[3:0] == 4'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every out_valid strobe must match the next predicted OUT value
    initial begin
        logic prev_ov;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid) begin
                    chk("out_valid_single_cycle", {31'd0, prev_ov}, 32'd0);
                    chk("out_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
                    if (first_out_cyc < 0) first_out_cyc = cyc - cyc0;
                end
                prev_ov = out_valid;
            end
        end
    end

    // Instruction-level reference: runs the ROM as a program, not a state machine
    task automatic model_run(output bit ok);
        logic [3:0] pc, acc, op, opd;
        logic [4:0] t;
        logic c, z;
        bit done;
        logic [3:0] outs [$];
        pc = 4'd0; acc = 4'd0; c = 1'b0; z = 1'b0; done = 1'b0; m_ill = 1'b0;
        for (int s = 0; s < 60 && !done; s++) begin
            op = rom[pc][7:4];
            opd = rom[pc][3:0];
            pc = pc + 4'd1;
            t = 5'd0;
            case (op)
                4'h1: acc = opd;
                4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                    if (op == 4'h2) t = acc + opd;
                    else if (op == 4'h3) t = {1'b0, acc} - {1'b0, opd};
                    else if (op == 4'h4) t = {1'b0, acc & opd};
                    else if (op == 4'h5) t = {1'b0, acc | opd};
                    else t = {1'b0, acc ^ opd};
                    acc = t[3:0];
                    c = t[4];
                    z = (acc == 4'd0);
                end
                4'h7: pc = opd;
                4'h8: if (z) pc = opd;
                4'h9: if (c) pc = opd;
                4'hA: outs.push_back(acc);
                4'hF: done = 1'b1;
`ifdef CPU_ILLEGAL_TRAP_EN
                4'hB, 4'hC, 4'hD, 4'hE: begin done = 1'b1; m_ill = 1'b1; end
`endif
                default: ;
            endcase
        end
        ok = done;
        if (done) begin
            foreach (outs[i]) exp_q.push_back(outs[i]);
            m_acc = acc; m_c = c; m_z = z; m_pc = pc;
        end
    endtask

    task automatic apply_reset(input logic run_at_release);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc", instr_addr, 4'd0);
        chk("rst_acc", acc_out, 4'd0);
        chk("rst_flags", {flag_c, flag_z}, 2'b00);
        chk("rst_out", {out_data, out_valid}, 5'd0);
        chk("rst_halt_ill", {halted, illegal}, 2'b00);
        chk("rst_alu_ops", {alu_a, alu_b, alu_sel}, 11'd0);
        rst = 1'b0;
        run = run_at_release;
        cyc0 = cyc;
        first_out_cyc = -1;
    endtask

    task automatic run_prog(input string name, input bit stall, input int pre_stall);
        bit ok;
        logic [3:0] hold_addr;
        model_run(ok);
        chk({name, "_model_halts"}, {31'd0, ok}, 32'd1);
        if (!ok) return;
        apply_reset(pre_stall == 0);
        for (int i = 0; i < pre_stall; i++) begin
            @(negedge clk);
            chk({name, "_stall_pc"}, instr_addr, 4'd0);
        end
        run = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (halted) break;
            run = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        halt_cyc = cyc - cyc0;
        chk({name, "_halted"}, {31'd0, halted}, 32'd1);
        chk({name, "_acc"}, acc_out, m_acc);
        chk({name, "_flags"}, {flag_c, flag_z}, {m_c, m_z});
        chk({name, "_pc"}, instr_addr, m_pc);
        chk({name, "_illegal"}, {31'd0, illegal}, {31'd0, m_ill});
        chk({name, "_outs_drained"}, exp_q.size(), 32'd0);
        exp_q.delete();
        hold_addr = instr_addr;
        run = 1'b1;
        repeat (4) @(negedge clk);
        chk({name, "_halt_holds_pc"}, instr_addr, hold_addr);
        chk({name, "_halt_sticky"}, {31'd0, halted}, 32'd1);
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    initial begin
        logic [7:0] b;
        bit ok;
        fill_rom(8'hF0);

        // LDI 3, ADD 2, OUT, HLT: strobe after edge 9, halted after edge 12
        rom[0] = 8'h13; rom[1] = 8'h22; rom[2] = 8'hA0; rom[3] = 8'hF0;
        run_prog("p_add", 1'b0, 0);
        chk("p_add_out_cycle", first_out_cyc, 32'd9);
        chk("p_add_halt_cycle", halt_cyc, 32'd12);
        chk("p_add_acc_const", acc_out, 4'd5);

        // JZ taken skips the OUT at address 3
        fill_rom(8'hF0);
        rom[0] = 8'h15; rom[1] = 8'h35; rom[2] = 8'h86; rom[3] = 8'hA0;
        rom[6] = 8'h19; rom[7] = 8'hA0;
        run_prog("p_jz", 1'b0, 0);

        // Wrap to 0 with carry set, then JC 8
        fill_rom(8'hF0);
        rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h98;
        run_prog("p_jc", 1'b0, 0);
        chk("p_jc_flags_const", {acc_out, flag_c, flag_z}, 6'b000011);
        chk("p_jc_pc_const", instr_addr, 4'd9);

        fill_rom(8'hF0);
        rom[0] = 8'h1C; rom[1] = 8'h4A; rom[2] = 8'hA0;
        rom[3] = 8'h1C; rom[4] = 8'h5A; rom[5] = 8'hA0;
        rom[6] = 8'h1C; rom[7] = 8'h6A; rom[8] = 8'hA0;
        run_prog("p_logic", 1'b0, 0);

        // Initial stall, then JMP 15 / NOP at 15 wraps pc to 0 where JC is now taken
        fill_rom(8'hF0);
        rom[0] = 8'h94; rom[1] = 8'h1F; rom[2] = 8'h21; rom[3] = 8'h7F;
        rom[4] = 8'hA0; rom[5] = 8'hF0; rom[15] = 8'h00;
        run_prog("p_wrap", 1'b0, 5);

        fill_rom(8'hF0);
        rom[0] = 8'h1A; rom[1] = 8'hC3; rom[2] = 8'hA0;
        run_prog("p_illegal", 1'b0, 0);

        // Asynchronous reset while the third instruction is in DECODE
        fill_rom(8'hF0);
        rom[0] = 8'h15; rom[1] = 8'hA0; rom[2] = 8'h13;
        exp_q.push_back(4'd5);
        apply_reset(1'b1);
        repeat (7) @(posedge clk);
        #1;
        chk("mid_acc_before_rst", acc_out, 4'd5);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_pc", instr_addr, 4'd0);
        chk("mid_rst_acc_out", {acc_out, out_data, out_valid}, 9'd0);
        chk("mid_rst_alu", {alu_a, alu_b, alu_sel}, 11'd0);
        chk("mid_rst_status", {flag_c, flag_z, halted, illegal}, 4'd0);
        chk("mid_outs_drained", exp_q.size(), 32'd0);
        exp_q.delete();

        // Random programs with random run stalls
        for (int p = 0; p < 25; p++) begin
            ok = 1'b0;
            for (int tries = 0; tries < 50 && !ok; tries++) begin
                for (int k = 0; k < 16; k++) begin
                    b = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 99) < 12) b[7:4] = 4'hF;
                    else if (b[7:4] == 4'hF) b[7:4] = 4'h2;
                    rom[k] = b;
                end
                model_run(ok);
                exp_q.delete();
            end
            if (!ok) fill_rom(8'hF0);
            run_prog($sformatf("rnd%0d", p), 1'b1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
